// File: rtl/tl_tx_pkg.sv
// Shared TL TX definitions: FSM state encoding, EP bit position and header field offsets.
// The RX poisoned-TLP check uses the same EP position.
package tl_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_SEND_HDR = 2'd2,
        ST_SEND_DAT = 2'd3
    } tx_state_e;

    // Offsets within the first header DW (4DW header, DW0 in bits [31:0])
    localparam int TL_EP_BIT   = 14;
    localparam int TL_TD_BIT   = 15;
    localparam int TL_LEN_LSB  = 0;
    localparam int TL_LEN_W    = 10;
    localparam int TL_TYPE_LSB = 24;
    localparam int TL_FMT_LSB  = 29;

endpackage

// File: rtl/tl_tx_poison_data_buf.sv
// Payload store for one TLP: registered write port, asynchronous read port.
module tl_tx_poison_data_buf #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; a location is only read after it was written for the current TLP.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tl_tx_poison_inserter.sv
// Store-and-forward TX stage: buffers a TLP payload, then emits the header with EP set
// when any beat carried an upstream error, followed by the unchanged payload.
module tl_tx_poison_inserter
    import tl_tx_pkg::*;
#(
    parameter  int DATA_W    = 128,
    parameter  int HDR_W     = 128,
    parameter  int MAX_BEATS = 16,
    parameter  int EP_BIT    = TL_EP_BIT,
    parameter  int CNT_W     = 16,
    localparam int LEN_W     = $clog2(MAX_BEATS + 1),
    localparam int AW        = $clog2(MAX_BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_poisoned_en,
    input  logic              i_in_hdr_valid,
    output logic              o_in_hdr_ready,
    input  logic [HDR_W-1:0]  i_in_hdr,
    input  logic [LEN_W-1:0]  i_in_len,
    input  logic              i_in_dat_valid,
    output logic              o_in_dat_ready,
    input  logic [DATA_W-1:0] i_in_dat,
    input  logic              i_in_dat_err,
    input  logic              i_in_dat_last,
    output logic              o_out_hdr_valid,
    input  logic              i_out_hdr_ready,
    output logic [HDR_W-1:0]  o_out_hdr,
    output logic              o_out_dat_valid,
    input  logic              i_out_dat_ready,
    output logic [DATA_W-1:0] o_out_dat,
    output logic              o_out_dat_last,
    output logic              o_len_err,
    output logic [CNT_W-1:0]  o_poison_cnt
);

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_BEATS - 1);

    tx_state_e         r_state, w_state_nxt;
    logic [HDR_W-1:0]  r_hdr, r_out_hdr, w_hdr_ep;
    logic [LEN_W-1:0]  r_len, r_cnt, r_rd, w_cnt_inc;
    logic              r_poison_en, r_err_acc, r_len_err;
    logic [CNT_W-1:0]  r_poison_cnt;
    logic              w_hdr_hs, w_dat_hs, w_ohdr_hs, w_odat_hs;
    logic              w_end, w_mismatch, w_err_final, w_rd_last;
    logic [DATA_W-1:0] w_rdata;

    assign w_hdr_hs    = (r_state == ST_IDLE)     && i_in_hdr_valid;
    assign w_dat_hs    = (r_state == ST_COLLECT)  && i_in_dat_valid;
    assign w_ohdr_hs   = (r_state == ST_SEND_HDR) && i_out_hdr_ready;
    assign w_odat_hs   = (r_state == ST_SEND_DAT) && i_out_dat_ready;

    assign w_cnt_inc   = r_cnt + LEN_W'(1);
    assign w_end       = i_in_dat_last || (r_cnt == LAST_IDX);
    // A beat ending collection is a length error if it is not 'last' or the count disagrees.
    assign w_mismatch  = !i_in_dat_last || (w_cnt_inc != r_len);
    assign w_err_final = r_err_acc | i_in_dat_err | w_mismatch;
    assign w_rd_last   = (r_rd == r_cnt - LEN_W'(1));

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        w_hdr_ep = r_hdr;
        if (r_poison_en) begin
            w_hdr_ep[EP_BIT] = r_hdr[EP_BIT] | w_err_final;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_hdr_hs) w_state_nxt = (i_in_len == '0) ? ST_SEND_HDR : ST_COLLECT;
            ST_COLLECT:  if (w_dat_hs && w_end) w_state_nxt = ST_SEND_HDR;
            ST_SEND_HDR: if (w_ohdr_hs) w_state_nxt = (r_cnt == '0) ? ST_IDLE : ST_SEND_DAT;
            ST_SEND_DAT: if (w_odat_hs && w_rd_last) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr        <= '0;
            r_out_hdr    <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_rd         <= '0;
            r_poison_en  <= 1'b0;
            r_err_acc    <= 1'b0;
            r_len_err    <= 1'b0;
            r_poison_cnt <= '0;
        end else begin
            r_len_err <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_hdr_hs) begin
                    r_hdr       <= i_in_hdr;
                    r_len       <= i_in_len;
                    r_poison_en <= i_poisoned_en;
                    r_err_acc   <= 1'b0;
                    r_cnt       <= '0;
                    r_rd        <= '0;
                    // Nothing can be in error for an empty payload.
                    if (i_in_len == '0) r_out_hdr <= i_in_hdr;
                end
                ST_COLLECT: if (w_dat_hs) begin
                    r_cnt     <= w_cnt_inc;
                    r_err_acc <= r_err_acc | i_in_dat_err;
                    if (w_end) begin
                        r_err_acc <= w_err_final;
                        r_len_err <= w_mismatch;
                        r_out_hdr <= w_hdr_ep;
                    end
                end
                ST_SEND_HDR: if (w_ohdr_hs) begin
                    r_rd <= '0;
                    if (r_out_hdr[EP_BIT] && (r_poison_cnt != '1)) begin
                        r_poison_cnt <= r_poison_cnt + CNT_W'(1);
                    end
                end
                ST_SEND_DAT: if (w_odat_hs) r_rd <= r_rd + LEN_W'(1);
                default: ;
            endcase
        end
    end

    tl_tx_poison_data_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_BEATS)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_dat_hs),
        .i_waddr (r_cnt[AW-1:0]),
        .i_wdata (i_in_dat),
        .i_raddr (r_rd[AW-1:0]),
        .o_rdata (w_rdata)
    );

    assign o_in_hdr_ready  = (r_state == ST_IDLE);
    assign o_in_dat_ready  = (r_state == ST_COLLECT);
    assign o_out_hdr_valid = (r_state == ST_SEND_HDR);
    assign o_out_dat_valid = (r_state == ST_SEND_DAT);
    assign o_out_dat_last  = (r_state == ST_SEND_DAT) && w_rd_last;
    assign o_out_dat       = (r_state == ST_SEND_DAT) ? w_rdata : '0;
    assign o_out_hdr       = r_out_hdr;
    assign o_len_err       = r_len_err;
    assign o_poison_cnt    = r_poison_cnt;

endmodule

// File: tb/tb_tl_tx_poison_inserter.sv
// Directed bench for tl_tx_poison_inserter; small poison counter so saturation is reachable.
module tb_tl_tx_poison_inserter;

    localparam int DATA_W    = 128;
    localparam int HDR_W     = 128;
    localparam int MAX_BEATS = 16;
    localparam int EP_BIT    = 14;
    localparam int CNT_W     = 2;
    localparam int LEN_W     = $clog2(MAX_BEATS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              i_poisoned_en, i_in_hdr_valid, i_in_dat_valid, i_in_dat_err, i_in_dat_last;
    logic [HDR_W-1:0]  i_in_hdr;
    logic [LEN_W-1:0]  i_in_len;
    logic [DATA_W-1:0] i_in_dat;
    logic              i_out_hdr_ready, i_out_dat_ready;
    logic              o_in_hdr_ready, o_in_dat_ready, o_out_hdr_valid, o_out_dat_valid;
    logic              o_out_dat_last, o_len_err;
    logic [HDR_W-1:0]  o_out_hdr;
    logic [DATA_W-1:0] o_out_dat;
    logic [CNT_W-1:0]  o_poison_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tl_tx_poison_inserter #(
        .DATA_W(DATA_W), .HDR_W(HDR_W), .MAX_BEATS(MAX_BEATS), .EP_BIT(EP_BIT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .i_poisoned_en(i_poisoned_en),
        .i_in_hdr_valid(i_in_hdr_valid), .o_in_hdr_ready(o_in_hdr_ready),
        .i_in_hdr(i_in_hdr), .i_in_len(i_in_len),
        .i_in_dat_valid(i_in_dat_valid), .o_in_dat_ready(o_in_dat_ready),
        .i_in_dat(i_in_dat), .i_in_dat_err(i_in_dat_err), .i_in_dat_last(i_in_dat_last),
        .o_out_hdr_valid(o_out_hdr_valid), .i_out_hdr_ready(i_out_hdr_ready), .o_out_hdr(o_out_hdr),
        .o_out_dat_valid(o_out_dat_valid), .i_out_dat_ready(i_out_dat_ready), .o_out_dat(o_out_dat),
        .o_out_dat_last(o_out_dat_last), .o_len_err(o_len_err), .o_poison_cnt(o_poison_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_val(input int id, input int i);
        return {32'(id), 32'(i), 32'hA5A5_0000 + 32'(i), 32'h5A5A_0000 + 32'(id)};
    endfunction

    function automatic logic [HDR_W-1:0] with_ep(input logic [HDR_W-1:0] h);
        logic [HDR_W-1:0] r;
        r = h;
        r[EP_BIT] = 1'b1;
        return r;
    endfunction

    // All tasks start and end on a falling edge; the DUT samples on the following rising edge.
    task automatic push_hdr(input logic [HDR_W-1:0] h, input int len, input logic en);
        int t = 0;
        i_in_hdr_valid = 1'b1;
        i_in_hdr       = h;
        i_in_len       = LEN_W'(len);
        i_poisoned_en  = en;
        while (!o_in_hdr_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("hdr_accept_wait", o_in_hdr_ready, 1'b1);
        @(negedge clk);
        i_in_hdr_valid = 1'b0;
    endtask

    task automatic push_beat(input int id, input int i, input logic err, input logic last);
        int t = 0;
        i_in_dat_valid = 1'b1;
        i_in_dat       = beat_val(id, i);
        i_in_dat_err   = err;
        i_in_dat_last  = last;
        while (!o_in_dat_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("dat_accept_wait", o_in_dat_ready, 1'b1);
        @(negedge clk);
        i_in_dat_valid = 1'b0;
        i_in_dat_err   = 1'b0;
        i_in_dat_last  = 1'b0;
    endtask

    task automatic drain(input logic [HDR_W-1:0] eh, input int n, input int id, input bit stall);
        int t = 0;
        while (!o_out_hdr_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("out_hdr_valid", o_out_hdr_valid, 1'b1);
        check("out_hdr", o_out_hdr, eh);
        if (stall) begin
            i_out_hdr_ready = 1'b0;
            @(negedge clk);
            check("out_hdr_valid_stall", o_out_hdr_valid, 1'b1);
            check("out_hdr_stable", o_out_hdr, eh);
        end
        i_out_hdr_ready = 1'b1;
        @(negedge clk);
        i_out_hdr_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("out_dat_valid", o_out_dat_valid, 1'b1);
            if (stall && (i % 2 == 0)) begin
                @(negedge clk);
                check("out_dat_stable", o_out_dat, beat_val(id, i));
                check("out_dat_valid_stall", o_out_dat_valid, 1'b1);
            end
            check("out_dat", o_out_dat, beat_val(id, i));
            check("out_dat_last", o_out_dat_last, (i == n - 1));
            i_out_dat_ready = 1'b1;
            @(negedge clk);
            i_out_dat_ready = 1'b0;
        end
        check("end_out_dat_valid", o_out_dat_valid, 1'b0);
        check("end_in_hdr_ready", o_in_hdr_ready, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_hdr_ready"}, o_in_hdr_ready, 1'b1);
        check({tag, "_in_dat_ready"}, o_in_dat_ready, 1'b0);
        check({tag, "_out_hdr_valid"}, o_out_hdr_valid, 1'b0);
        check({tag, "_out_dat_valid"}, o_out_dat_valid, 1'b0);
        check({tag, "_out_dat_last"}, o_out_dat_last, 1'b0);
        check({tag, "_out_hdr"}, o_out_hdr, '0);
        check({tag, "_out_dat"}, o_out_dat, '0);
        check({tag, "_len_err"}, o_len_err, 1'b0);
        check({tag, "_poison_cnt"}, o_poison_cnt, '0);
    endtask

    localparam logic [HDR_W-1:0] H1 = 128'h0123_4567_89AB_CDEF_0000_0000_4000_0004;
    localparam logic [HDR_W-1:0] H2 = 128'hFEDC_BA98_7654_3210_1111_2222_0000_8003;
    localparam logic [HDR_W-1:0] H4 = 128'h1111_0000_2222_0000_3333_0000_0400_0004;
    localparam logic [HDR_W-1:0] H5 = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_6000_0010;
    localparam logic [HDR_W-1:0] H6 = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [HDR_W-1:0] H7 = 128'h7777_7777_7777_7777_7777_7777_7777_3001;
    localparam logic [HDR_W-1:0] H8 = 128'h8888_8888_8888_8888_8888_8888_8888_0004;
    localparam logic [HDR_W-1:0] H9 = 128'h9999_9999_9999_9999_9999_9999_9999_0002;

    initial begin
        rst = 1'b1;
        i_poisoned_en = 1'b0; i_in_hdr_valid = 1'b0; i_in_hdr = '0; i_in_len = '0;
        i_in_dat_valid = 1'b0; i_in_dat = '0; i_in_dat_err = 1'b0; i_in_dat_last = 1'b0;
        i_out_hdr_ready = 1'b0; i_out_dat_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Clean 4-beat TLP with poisoning enabled
        push_hdr(H1, 4, 1'b1);
        for (int i = 0; i < 4; i++) push_beat(1, i, 1'b0, i == 3);
        check("clean_hdr_latency", o_out_hdr_valid, 1'b1);
        check("clean_len_err", o_len_err, 1'b0);
        drain(H1, 4, 1, 1'b0);
        check("clean_poison_cnt", o_poison_cnt, 2'd0);

        // Error on beat 2 of 3, with output stalls
        push_hdr(H2, 3, 1'b1);
        for (int i = 0; i < 3; i++) push_beat(2, i, i == 1, i == 2);
        check("poison_len_err", o_len_err, 1'b0);
        drain(with_ep(H2), 3, 2, 1'b1);
        check("poison_cnt_1", o_poison_cnt, 2'd1);

        // Same stimulus with insertion disabled; enable flipped mid-TLP must not matter
        push_hdr(H2, 3, 1'b0);
        i_poisoned_en = 1'b1;
        for (int i = 0; i < 3; i++) push_beat(3, i, i == 1, i == 2);
        i_poisoned_en = 1'b0;
        drain(H2, 3, 3, 1'b0);
        check("disabled_poison_cnt", o_poison_cnt, 2'd1);

        // in_len=4 but last on beat 2
        push_hdr(H4, 4, 1'b1);
        for (int i = 0; i < 2; i++) push_beat(4, i, 1'b0, i == 1);
        check("short_len_err_pulse", o_len_err, 1'b1);
        @(negedge clk);
        check("short_len_err_clear", o_len_err, 1'b0);
        drain(with_ep(H4), 2, 4, 1'b0);
        check("poison_cnt_2", o_poison_cnt, 2'd2);

        // 17 beats without last: collection ends at beat 16, beat 17 refused
        push_hdr(H5, 16, 1'b1);
        for (int i = 0; i < 16; i++) push_beat(5, i, 1'b0, 1'b0);
        check("ovf_len_err_pulse", o_len_err, 1'b1);
        check("ovf_hdr_valid", o_out_hdr_valid, 1'b1);
        i_in_dat_valid = 1'b1;
        i_in_dat = beat_val(5, 16);
        check("ovf_in_dat_ready", o_in_dat_ready, 1'b0);
        @(negedge clk);
        check("ovf_len_err_clear", o_len_err, 1'b0);
        check("ovf_in_dat_ready_2", o_in_dat_ready, 1'b0);
        i_in_dat_valid = 1'b0;
        drain(with_ep(H5), 16, 5, 1'b1);
        check("poison_cnt_3", o_poison_cnt, 2'd3);

        // Zero-length TLP: header presented on the cycle after acceptance
        push_hdr(H6, 0, 1'b1);
        check("zero_hdr_latency", o_out_hdr_valid, 1'b1);
        check("zero_in_dat_ready", o_in_dat_ready, 1'b0);
        drain(H6, 0, 6, 1'b0);
        check("zero_out_dat_valid", o_out_dat_valid, 1'b0);
        check("zero_poison_cnt", o_poison_cnt, 2'd3);

        // Counter already at all-ones must saturate
        push_hdr(H7, 1, 1'b1);
        push_beat(7, 0, 1'b1, 1'b1);
        drain(with_ep(H7), 1, 7, 1'b0);
        check("sat_poison_cnt", o_poison_cnt, 2'd3);

        // Reset in the middle of collection, then a clean TLP
        push_hdr(H8, 4, 1'b1);
        push_beat(8, 0, 1'b1, 1'b0);
        push_beat(8, 1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        push_hdr(H9, 2, 1'b1);
        for (int i = 0; i < 2; i++) push_beat(9, i, 1'b0, i == 1);
        check("after_rst_len_err", o_len_err, 1'b0);
        drain(H9, 2, 9, 1'b1);
        check("after_rst_poison_cnt", o_poison_cnt, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

endmodule
